// File: rtl/dot_matrix_row_scanner.sv
`default_nettype none
// ============================================================================
// Module      : dot_matrix_row_scanner
// Description : Row-multiplexed driver for a 3-column x 5-row LED matrix.
//               Captures a 15-bit 3x5 dot pattern into a shadow register and
//               scans it one row at a time. Each row is preceded by an
//               all-off blanking gap. The displayed pattern is swapped in
//               only at frame start, so a symbol never tears mid-frame.
// Ports       : clk        - system clock, rising edge
//               rst        - asynchronous active-high reset
//               dots_in    - pattern, row r = dots_in[14-3r -: 3], MSB = left
//               load       - 1-cycle strobe, capture dots_in into shadow
//               enable     - 1 = scan, 0 = display off
//               row_sel    - one-hot row drive, bit r = row r (row 0 = top)
//               col_out    - column drive, col_out[2] = left column
//               frame_done - 1-cycle pulse after row 4 finishes driving
// Revision    : 1.0 - initial release
// ============================================================================
module dot_matrix_row_scanner #(
    parameter int ROW_CYCLES   = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [14:0] dots_in,
    input  logic        load,
    input  logic        enable,
    output logic [4:0]  row_sel,
    output logic [2:0]  col_out,
    output logic        frame_done
);

    localparam int MAX_CYCLES = (ROW_CYCLES > BLANK_CYCLES) ? ROW_CYCLES : BLANK_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(ROW_CYCLES - 1);
    // With no blanking the BLANK state is never entered; clamp to keep width legal.
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    // State entered at the start of every row.
    localparam state_t ROW_ENTRY = (BLANK_CYCLES == 0) ? DRIVE : BLANK;

    state_t             state, state_n;
    logic [2:0]         row, row_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [14:0]        shadow;
    logic [14:0]        active, active_n;
    logic [14:0]        swap_val;
    logic               wrap;

    function automatic logic [2:0] row_cols(input logic [14:0] pat, input logic [2:0] r);
        logic [2:0] c;
        case (r)
            3'd0:    c = pat[14:12];
            3'd1:    c = pat[11:9];
            3'd2:    c = pat[8:6];
            3'd3:    c = pat[5:3];
            3'd4:    c = pat[2:0];
            default: c = 3'b000;
        endcase
        return c;
    endfunction

    // A load coinciding with the swap bypasses the shadow so the newest value wins.
    assign swap_val = load ? dots_in : shadow;

    always_comb begin
        state_n  = state;
        row_n    = row;
        cnt_n    = cnt + CNT_ONE;
        active_n = active;
        wrap     = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                row_n = 3'd0;
                if (enable) begin
                    state_n  = ROW_ENTRY;
                    active_n = swap_val;
                end
            end
            BLANK: begin
                if (!enable) begin
                    state_n = IDLE;
                    row_n   = 3'd0;
                    cnt_n   = '0;
                end else if (cnt == BLANK_LAST) begin
                    state_n = DRIVE;
                    cnt_n   = '0;
                end
            end
            DRIVE: begin
                if (!enable) begin
                    state_n = IDLE;
                    row_n   = 3'd0;
                    cnt_n   = '0;
                end else if (cnt == ROW_LAST) begin
                    state_n = ROW_ENTRY;
                    cnt_n   = '0;
                    if (row == 3'd4) begin
                        row_n    = 3'd0;
                        active_n = swap_val;
                        wrap     = 1'b1;
                    end else begin
                        row_n = row + 3'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                row_n   = 3'd0;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up with
    // the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            row        <= 3'd0;
            cnt        <= '0;
            shadow     <= 15'd0;
            active     <= 15'd0;
            row_sel    <= 5'd0;
            col_out    <= 3'd0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            row        <= row_n;
            cnt        <= cnt_n;
            active     <= active_n;
            frame_done <= wrap;
            if (load) begin
                shadow <= dots_in;
            end
            if (state_n == DRIVE) begin
                row_sel <= 5'b00001 << row_n;
                col_out <= row_cols(active_n, row_n);
            end else begin
                row_sel <= 5'd0;
                col_out <= 3'd0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dot_matrix_row_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_dot_matrix_row_scanner
// Description : Self-checking bench for dot_matrix_row_scanner. Two instances
//               share stimulus: one with 2 blanking cycles, one with none.
//               Each is compared every cycle against a time-arithmetic model
//               (frame position -> row / blank / pattern), plus hand-written
//               constant checks for the directed corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dot_matrix_row_scanner;

    localparam int R  = 4;
    localparam int BA = 2;
    localparam int BB = 0;

    logic        clk;
    logic        rst;
    logic [14:0] dots_in;
    logic        load;
    logic        enable;
    logic [4:0]  rs_a, rs_b;
    logic [2:0]  col_a, col_b;
    logic        fd_a, fd_b;

    int checks = 0;
    int errors = 0;

    dot_matrix_row_scanner #(.ROW_CYCLES(R), .BLANK_CYCLES(BA)) dut_a (
        .clk(clk), .rst(rst), .dots_in(dots_in), .load(load), .enable(enable),
        .row_sel(rs_a), .col_out(col_a), .frame_done(fd_a)
    );

    dot_matrix_row_scanner #(.ROW_CYCLES(R), .BLANK_CYCLES(BB)) dut_b (
        .clk(clk), .rst(rst), .dots_in(dots_in), .load(load), .enable(enable),
        .row_sel(rs_b), .col_out(col_b), .frame_done(fd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: time since the scan started, and the pattern
    // latched at each frame start. Index 0 = instance A, 1 = instance B.
    // ------------------------------------------------------------------
    bit          m_run [2];
    int          m_t   [2];
    logic [14:0] m_pat [2];
    logic [14:0] m_shadow;

    function automatic int blank_of(input int i);
        return (i == 0) ? BA : BB;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_run[i] <= 1'b0;
                m_t[i]   <= 0;
                m_pat[i] <= 15'd0;
            end
            m_shadow <= 15'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!m_run[i]) begin
                    if (enable) begin
                        m_run[i] <= 1'b1;
                        m_t[i]   <= 0;
                        m_pat[i] <= load ? dots_in : m_shadow;
                    end
                end else if (!enable) begin
                    m_run[i] <= 1'b0;
                    m_t[i]   <= 0;
                end else begin
                    m_t[i] <= m_t[i] + 1;
                    if ((m_t[i] + 1) % (5 * (R + blank_of(i))) == 0)
                        m_pat[i] <= load ? dots_in : m_shadow;
                end
            end
            if (load) m_shadow <= dots_in;
        end
    end

    task automatic model_out(input int i, output logic [4:0] rs, output logic [2:0] col,
                             output logic fd);
        int per, pos, r, w;
        per = R + blank_of(i);
        pos = m_t[i] % (5 * per);
        r   = pos / per;
        w   = pos % per;
        rs  = 5'd0;
        col = 3'd0;
        fd  = 1'b0;
        if (m_run[i]) begin
            if (w >= blank_of(i)) begin
                rs  = 5'(1 << r);
                col = 3'((m_pat[i] >> (12 - 3 * r)) & 15'h7);
            end
            fd = (m_t[i] > 0) && (pos == 0);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_models();
        logic [4:0] rs;
        logic [2:0] col;
        logic       fd;
        model_out(0, rs, col, fd);
        chk("a_row_sel", 32'(rs_a), 32'(rs));
        chk("a_col_out", 32'(col_a), 32'(col));
        chk("a_frame_done", 32'(fd_a), 32'(fd));
        model_out(1, rs, col, fd);
        chk("b_row_sel", 32'(rs_b), 32'(rs));
        chk("b_col_out", 32'(col_b), 32'(col));
        chk("b_frame_done", 32'(fd_b), 32'(fd));
    endtask

    // One clock: inputs already set at the falling edge, outputs checked at
    // the next falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_models();
    endtask

    // Stop, load a pattern, and start a fresh scan. After return, the next
    // tick lands on scan cycle k=0 (first blank cycle).
    task automatic restart(input logic [14:0] pat);
        enable  = 1'b0;
        tick();
        dots_in = pat;
        load    = 1'b1;
        tick();
        load    = 1'b0;
        enable  = 1'b1;
    endtask

    typedef struct {
        logic [14:0]      pat;
        logic [0:4][2:0]  cols;
    } vec_t;

    vec_t tbl [4];

    localparam logic [14:0] ZERO_PAT = 15'b111_101_101_101_111;
    localparam logic [14:0] NEW_PAT  = 15'b010_110_010_010_011;
    localparam logic [14:0] X_PAT    = 15'b100_010_001_010_100;

    initial begin
        int fd_cnt;
        bit b_gap;

        tbl[0] = '{ZERO_PAT, {3'b111, 3'b101, 3'b101, 3'b101, 3'b111}};
        tbl[1] = '{NEW_PAT,  {3'b010, 3'b110, 3'b010, 3'b010, 3'b011}};
        tbl[2] = '{15'd0,    {3'b000, 3'b000, 3'b000, 3'b000, 3'b000}};
        tbl[3] = '{X_PAT,    {3'b100, 3'b010, 3'b001, 3'b010, 3'b100}};

        rst     = 1'b1;
        load    = 1'b0;
        enable  = 1'b0;
        dots_in = 15'd0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_row_sel", 32'(rs_a), 32'd0);
        chk("reset_col_out", 32'(col_a), 32'd0);
        chk("reset_frame_done", 32'(fd_a), 32'd0);
        rst = 1'b0;
        tick();
        tick();

        // Table-driven: one full frame per pattern, row columns against constants.
        foreach (tbl[v]) begin
            restart(tbl[v].pat);
            for (int k = 0; k <= 30; k++) begin
                tick();
                if (k < 30 && (k % 6) == 2) begin
                    chk("tbl_row_sel", 32'(rs_a), 32'(5'b00001 << (k / 6)));
                    chk("tbl_col", 32'(col_a), 32'(tbl[v].cols[k / 6]));
                end
                if (k == 1) chk("tbl_blank", 32'(rs_a), 32'd0);
                if (k == 29) chk("tbl_fd_low", 32'(fd_a), 32'd0);
                if (k == 30) chk("tbl_fd_high", 32'(fd_a), 32'd1);
            end
        end

        // Mid-frame load during row 2: current frame unchanged, next frame new.
        restart(ZERO_PAT);
        for (int k = 0; k <= 56; k++) begin
            tick();
            if (k == 20) chk("midload_cur_row3", 32'(col_a), 32'b101);
            if (k == 26) chk("midload_cur_row4", 32'(col_a), 32'b111);
            if (k == 32) chk("midload_next_row0", 32'(col_a), 32'b010);
            if (k == 38) chk("midload_next_row1", 32'(col_a), 32'b110);
            if (k == 56) chk("midload_next_row4", 32'(col_a), 32'b011);
            load = 1'b0;
            if (k == 14) begin
                dots_in = NEW_PAT;
                load    = 1'b1;
            end
        end
        load = 1'b0;

        // Drop enable during row 2 drive, then re-enable.
        restart(ZERO_PAT);
        for (int k = 0; k <= 14; k++) tick();
        chk("dis_pre_row2", 32'(rs_a), 32'b00100);
        enable = 1'b0;
        tick();
        chk("dis_row_sel", 32'(rs_a), 32'd0);
        chk("dis_col", 32'(col_a), 32'd0);
        chk("dis_fd", 32'(fd_a), 32'd0);
        enable = 1'b1;
        tick();
        chk("reen_blank0", 32'(rs_a), 32'd0);
        tick();
        chk("reen_blank1", 32'(rs_a), 32'd0);
        tick();
        chk("reen_row0", 32'(rs_a), 32'b00001);
        chk("reen_col0", 32'(col_a), 32'b111);

        // Load in the swap cycle (last drive cycle of row 4).
        restart(ZERO_PAT);
        for (int k = 0; k <= 38; k++) begin
            tick();
            load = 1'b0;
            if (k == 29) begin
                chk("swap_last_row4", 32'(rs_a), 32'b10000);
                dots_in = X_PAT;
                load    = 1'b1;
            end
            if (k == 30) chk("swap_fd", 32'(fd_a), 32'd1);
            if (k == 32) chk("swap_row0", 32'(col_a), 32'b100);
            if (k == 38) chk("swap_row1", 32'(col_a), 32'b010);
        end
        load = 1'b0;

        // No-blanking instance: back-to-back rows, 20-cycle frame.
        restart(NEW_PAT);
        fd_cnt = 0;
        b_gap  = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            tick();
            if (k == 0) chk("nob_first_row0", 32'(rs_b), 32'b00001);
            if (rs_b == 5'd0) b_gap = 1'b1;
            if (fd_b) fd_cnt++;
            if (k == 20) chk("nob_fd_20", 32'(fd_b), 32'd1);
            if (k == 19) chk("nob_fd_19", 32'(fd_b), 32'd0);
        end
        chk("nob_no_gap", 32'(b_gap), 32'd0);
        chk("nob_fd_count", 32'(fd_cnt), 32'd2);

        // Asynchronous reset mid-drive: outputs clear before the next edge.
        restart(ZERO_PAT);
        for (int k = 0; k <= 3; k++) tick();
        chk("arst_pre_drive", 32'(rs_a), 32'b00001);
        #2 rst = 1'b1;
        #1;
        chk("arst_row_sel", 32'(rs_a), 32'd0);
        chk("arst_col", 32'(col_a), 32'd0);
        chk("arst_fd", 32'(fd_a), 32'd0);
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("arst_hold", 32'(rs_a), 32'd0);
        end

        // Randomized traffic with occasional loads and enable drops.
        enable = 1'b1;
        for (int n = 0; n < 600; n++) begin
            load    = ($urandom_range(0, 7) == 0);
            dots_in = 15'($urandom);
            enable  = ($urandom_range(0, 59) != 0);
            tick();
        end
        load   = 1'b0;
        enable = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
